imm_gen_stage: RTL and testbench

//  Pipelined, parametrised immediate generator between IF/ID and the register-read/ALU stages.

---
 rtl/imm_gen_stage_pkg.sv | 37 +++
 rtl/imm_decode.sv | 45 ++++
 rtl/imm_gen_stage.sv | 102 ++++++++++
 tb/tb_imm_gen_stage.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/imm_gen_stage_pkg.sv
// Shared definitions for the immediate generator: immediate classes, opcode
// patterns and the sign-extension helper used by the decoder.
package imm_gen_stage_pkg;

    typedef enum logic [2:0] {
        IMM_NONE  = 3'd0,
        IMM_B     = 3'd1,
        IMM_CB    = 3'd2,
        IMM_D     = 3'd3,
        IMM_SHAMT = 3'd4,
        IMM_I     = 3'd5,
        IMM_MOV   = 3'd6
    } imm_kind_e;

    // Opcode fields, each compared against its own slice of the instruction.
    localparam logic [5:0]  OP_B    = 6'b000101;       // [31:26]
    localparam logic [5:0]  OP_BL   = 6'b100101;       // [31:26]
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;     // [31:24]
    localparam logic [7:0]  OP_CBNZ = 8'b10110101;     // [31:24]
    localparam logic [10:0] OP_LDUR = 11'b11111000010; // [31:21]
    localparam logic [10:0] OP_STUR = 11'b11111000000; // [31:21]
    localparam logic [10:0] OP_LSL  = 11'b11010011011; // [31:21]
    localparam logic [10:0] OP_LSR  = 11'b11010011010; // [31:21]
    localparam logic [9:0]  OP_ADDI = 10'b1001000100;  // [31:22]
    localparam logic [9:0]  OP_SUBI = 10'b1101000100;  // [31:22]
    localparam logic [8:0]  OP_MOVZ = 9'b110100101;    // [31:23]

    localparam int unsigned DEPTH = 2;

    // Sign-extend the low w bits of v to 64 bits.
    function automatic logic [63:0] sext_to64(input logic [63:0] v, input int w);
        logic signed [63:0] t;
        t = $signed(v << (64 - w));
        return $unsigned(t >>> (64 - w));
    endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decoder: classifies an instruction and produces the
// DATA_W-bit extended immediate for its class.
module imm_decode
    import imm_gen_stage_pkg::*;
#(
    parameter int DATA_W       = 64,
    parameter int BRANCH_SHIFT = 1
) (
    input  logic [31:0]       instr,
    output logic [DATA_W-1:0] imm,
    output imm_kind_e         kind
);

    logic [63:0] full;

    always_comb begin
        kind = IMM_NONE;
        full = sext_to64({32'b0, instr}, 32);
        if (instr[31:26] == OP_B || instr[31:26] == OP_BL) begin
            kind = IMM_B;
            full = sext_to64({38'b0, instr[25:0]}, 26);
            if (BRANCH_SHIFT != 0) full = {full[61:0], 2'b00};
        end else if (instr[31:24] == OP_CBZ || instr[31:24] == OP_CBNZ) begin
            kind = IMM_CB;
            full = sext_to64({45'b0, instr[23:5]}, 19);
            if (BRANCH_SHIFT != 0) full = {full[61:0], 2'b00};
        end else if (instr[31:21] == OP_LDUR || instr[31:21] == OP_STUR) begin
            kind = IMM_D;
            full = sext_to64({55'b0, instr[20:12]}, 9);
        end else if (instr[31:21] == OP_LSL || instr[31:21] == OP_LSR) begin
            kind = IMM_SHAMT;
            full = {58'b0, instr[15:10]};
        end else if (instr[31:22] == OP_ADDI || instr[31:22] == OP_SUBI) begin
            kind = IMM_I;
            full = {52'b0, instr[21:10]};
        end else if (instr[31:23] == OP_MOVZ) begin
            // Bits pushed above DATA_W-1 fall off in the truncation below.
            kind = IMM_MOV;
            full = {48'b0, instr[20:5]} << {instr[22:21], 4'b0000};
        end
    end

    assign imm = full[DATA_W-1:0];

endmodule

// File: rtl/imm_gen_stage.sv
// Immediate generator stage: decodes at push time and holds results in a
// 2-entry skid buffer with valid/ready handshakes and synchronous flush.
module imm_gen_stage
    import imm_gen_stage_pkg::*;
#(
    parameter int DATA_W       = 64,
    parameter int BRANCH_SHIFT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_imm,
    output logic [2:0]        out_kind,
    output logic [31:0]       out_instr
);

    logic [DATA_W-1:0] dec_imm;
    imm_kind_e         dec_kind;

    imm_decode #(
        .DATA_W       (DATA_W),
        .BRANCH_SHIFT (BRANCH_SHIFT)
    ) u_decode (
        .instr (in_instr),
        .imm   (dec_imm),
        .kind  (dec_kind)
    );

    logic [31:0]       instr_q [DEPTH];
    logic [31:0]       instr_d [DEPTH];
    logic [DATA_W-1:0] imm_q   [DEPTH];
    logic [DATA_W-1:0] imm_d   [DEPTH];
    imm_kind_e         kind_q  [DEPTH];
    imm_kind_e         kind_d  [DEPTH];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        count_q, count_d;
    logic              push, pop;

    // Handshake flags come straight from the count register.
    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        instr_d  = instr_q;
        imm_d    = imm_q;
        kind_d   = kind_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push) begin
                instr_d[wr_ptr_q] = in_instr;
                imm_d[wr_ptr_q]   = dec_imm;
                kind_d[wr_ptr_q]  = dec_kind;
                wr_ptr_d          = ~wr_ptr_q;
            end
            if (pop) rd_ptr_d = ~rd_ptr_q;
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                instr_q[i] <= '0;
                imm_q[i]   <= '0;
                kind_q[i]  <= IMM_NONE;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            instr_q  <= instr_d;
            imm_q    <= imm_d;
            kind_q   <= kind_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign out_imm   = imm_q[rd_ptr_q];
    assign out_kind  = kind_q[rd_ptr_q];
    assign out_instr = instr_q[rd_ptr_q];

endmodule

// File: tb/tb_imm_gen_stage.sv
// Scoreboard bench: two instances (64-bit/shifted and 32-bit/unshifted) share
// stimulus; a queue model of the buffer is compared at every falling edge.
module tb_imm_gen_stage;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic [31:0] in_instr;

    logic        in_ready_a, out_valid_a;
    logic [63:0] out_imm_a;
    logic [2:0]  out_kind_a;
    logic [31:0] out_instr_a;
    logic        in_ready_b, out_valid_b;
    logic [31:0] out_imm_b;
    logic [2:0]  out_kind_b;
    logic [31:0] out_instr_b;

    imm_gen_stage #(.DATA_W(64), .BRANCH_SHIFT(1)) dut_a (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_instr(in_instr),
        .out_valid(out_valid_a), .out_ready(out_ready),
        .out_imm(out_imm_a), .out_kind(out_kind_a), .out_instr(out_instr_a)
    );

    imm_gen_stage #(.DATA_W(32), .BRANCH_SHIFT(0)) dut_b (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_instr(in_instr),
        .out_valid(out_valid_b), .out_ready(out_ready),
        .out_imm(out_imm_b), .out_kind(out_kind_b), .out_instr(out_instr_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  kind;
        logic [63:0] imm64;
        logic [31:0] imm32;
    } exp_t;

    exp_t sbq[$];
    exp_t pend;
    int   errors = 0;
    int   checks = 0;
    bit   mpop, mpush;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] sx(input logic [63:0] v, input int n);
        if (v[n-1]) return v | (~64'd0 << n);
        return v;
    endfunction

    function automatic logic [2:0] ref_kind(input logic [31:0] i);
        if ((i >> 26) == 32'h05 || (i >> 26) == 32'h25)   return 3'd1;
        if ((i >> 24) == 32'hB4 || (i >> 24) == 32'hB5)   return 3'd2;
        if ((i >> 21) == 32'h7C2 || (i >> 21) == 32'h7C0) return 3'd3;
        if ((i >> 21) == 32'h69B || (i >> 21) == 32'h69A) return 3'd4;
        if ((i >> 22) == 32'h244 || (i >> 22) == 32'h344) return 3'd5;
        if ((i >> 23) == 32'h1A5)                         return 3'd6;
        return 3'd0;
    endfunction

    function automatic logic [63:0] ref_imm(input logic [31:0] i, input int dw, input bit bs);
        logic [63:0] v;
        case (ref_kind(i))
            3'd1: begin v = sx(64'(i[25:0]), 26); if (bs) v = v * 4; end
            3'd2: begin v = sx(64'(i[23:5]), 19); if (bs) v = v * 4; end
            3'd3: v = sx(64'(i[20:12]), 9);
            3'd4: v = 64'(i[15:10]);
            3'd5: v = 64'(i[21:10]);
            3'd6: v = 64'(i[20:5]) << (16 * i[22:21]);
            default: v = sx(64'(i), 32);
        endcase
        if (dw < 64) v = v & ((64'd1 << dw) - 64'd1);
        return v;
    endfunction

    function automatic exp_t mk(input logic [31:0] i);
        exp_t e;
        e.instr = i;
        e.kind  = ref_kind(i);
        e.imm64 = ref_imm(i, 64, 1'b1);
        e.imm32 = 32'(ref_imm(i, 32, 1'b0));
        return e;
    endfunction

    function automatic exp_t dexp(input logic [31:0] i, input logic [2:0] k,
                                  input logic [63:0] i64, input logic [31:0] i32);
        exp_t e;
        e.instr = i; e.kind = k; e.imm64 = i64; e.imm32 = i32;
        return e;
    endfunction

    function automatic logic [31:0] gen();
        logic [31:0] r;
        bit          alt;
        r   = $urandom;
        alt = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 7))
            0: return (alt ? 32'h94000000 : 32'h14000000) | (r & 32'h03FFFFFF);
            1: return (alt ? 32'hB5000000 : 32'hB4000000) | (r & 32'h00FFFFFF);
            2: return ((alt ? 32'h7C2 : 32'h7C0) << 21) | (r & 32'h001FFFFF);
            3: return ((alt ? 32'h69B : 32'h69A) << 21) | (r & 32'h001FFFFF);
            4: return ((alt ? 32'h244 : 32'h344) << 22) | (r & 32'h003FFFFF);
            5: return (32'h1A5 << 23) | (r & 32'h007FFFFF);
            default: return r;
        endcase
    endfunction

    task automatic cyc(input bit v, input logic [31:0] ins, input exp_t e,
                       input bit rdy, input bit fl);
        @(negedge clk);
        #2;
        in_valid  = v;
        in_instr  = ins;
        pend      = e;
        out_ready = rdy;
        flush     = fl;
        @(posedge clk);
    endtask

    task automatic rnd(input bit v, input bit rdy, input bit fl);
        logic [31:0] i;
        i = gen();
        cyc(v, i, mk(i), rdy, fl);
    endtask

    // Reference buffer: flush and reset empty it; otherwise pop head, append accepted entry.
    always @(posedge clk or posedge reset) begin
        if (reset) sbq.delete();
        else if (flush) sbq.delete();
        else begin
            mpop  = (sbq.size() != 0) && out_ready;
            mpush = in_valid && (sbq.size() < 2);
            if (mpop) void'(sbq.pop_front());
            if (mpush) sbq.push_back(pend);
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("in_ready_a", 64'(in_ready_a), 64'(sbq.size() < 2));
            chk("out_valid_a", 64'(out_valid_a), 64'(sbq.size() != 0));
            chk("in_ready_b", 64'(in_ready_b), 64'(sbq.size() < 2));
            chk("out_valid_b", 64'(out_valid_b), 64'(sbq.size() != 0));
            if (sbq.size() != 0) begin
                chk("instr_a", 64'(out_instr_a), 64'(sbq[0].instr));
                chk("kind_a", 64'(out_kind_a), 64'(sbq[0].kind));
                chk("imm_a", out_imm_a, sbq[0].imm64);
                chk("instr_b", 64'(out_instr_b), 64'(sbq[0].instr));
                chk("kind_b", 64'(out_kind_b), 64'(sbq[0].kind));
                chk("imm_b", 64'(out_imm_b), 64'(sbq[0].imm32));
            end
        end
    end

    exp_t dir[$];

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_instr = '0;
        pend = mk(32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid_a", 64'(out_valid_a), 64'd0);
        chk("rst_ready_a", 64'(in_ready_a), 64'd1);
        chk("rst_imm_a", out_imm_a, 64'd0);
        chk("rst_kind_a", 64'(out_kind_a), 64'd0);
        chk("rst_instr_a", 64'(out_instr_a), 64'd0);
        chk("rst_imm_b", 64'(out_imm_b), 64'd0);
        @(negedge clk);
        #2 reset = 1'b0;

        // Spec vectors with fixed expectations for both parameter sets.
        dir.push_back(dexp(32'h17FFFFFF, 3'd1, 64'hFFFFFFFFFFFFFFFC, 32'hFFFFFFFF));
        dir.push_back(dexp(32'hB4FFFFE0, 3'd2, 64'hFFFFFFFFFFFFFFFC, 32'hFFFFFFFF));
        dir.push_back(dexp(32'hF8500000, 3'd3, 64'hFFFFFFFFFFFFFF00, 32'hFFFFFF00));
        dir.push_back(dexp(32'hD2D7DDE0, 3'd6, 64'h0000BEEF00000000, 32'h00000000));
        dir.push_back(dexp(32'hD360FC00, 3'd4, 64'h000000000000003F, 32'h0000003F));
        dir.push_back(dexp(32'hD340FC00, 3'd4, 64'h000000000000003F, 32'h0000003F));
        dir.push_back(dexp(32'h8B000000, 3'd0, 64'hFFFFFFFF8B000000, 32'h8B000000));
        dir.push_back(dexp(32'h913FFC00, 3'd5, 64'h0000000000000FFF, 32'h00000FFF));
        foreach (dir[k]) cyc(1'b1, dir[k].instr, dir[k], 1'b1, 1'b0);
        cyc(1'b0, 32'h0, mk(32'h0), 1'b1, 1'b0);

        // Back-pressure: third push is refused, then drain with no gaps.
        repeat (3) rnd(1'b1, 1'b0, 1'b0);
        repeat (3) rnd(1'b0, 1'b1, 1'b0);

        // Push+pop at count 1, then flush overriding a push.
        rnd(1'b1, 1'b0, 1'b0);
        rnd(1'b1, 1'b1, 1'b0);
        rnd(1'b1, 1'b0, 1'b0);
        rnd(1'b1, 1'b1, 1'b1);
        rnd(1'b0, 1'b0, 1'b0);

        // Asynchronous reset while full.
        rnd(1'b1, 1'b0, 1'b0);
        rnd(1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("arst_valid_a", 64'(out_valid_a), 64'd0);
        chk("arst_ready_a", 64'(in_ready_a), 64'd1);
        chk("arst_valid_b", 64'(out_valid_b), 64'd0);
        chk("arst_ready_b", 64'(in_ready_b), 64'd1);
        in_valid = 1'b0;
        @(negedge clk);
        #2 reset = 1'b0;
        rnd(1'b1, 1'b0, 1'b0);
        rnd(1'b0, 1'b1, 1'b0);

        repeat (600)
            rnd($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                $urandom_range(0, 15) == 0);
        repeat (3) rnd(1'b0, 1'b1, 1'b0);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
